// File: rtl/rx_buffer.sv
// Receive-side byte buffer: takes bytes from the UART receiver handshake and holds them in a
// first-word-fall-through FIFO with per-byte parity flag, overflow and parity-error statistics.
module rx_buffer #(
    parameter int DEPTH    = 8,
    parameter bit DROP_ERR = 1'b0
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic                     Receive,
    input  logic [7:0]               Dout,
    input  logic                     parityErr,
    output logic                     Received,
    input  logic                     pop,
    output logic [7:0]               rdData,
    output logic                     rdErr,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clrOverflow,
    output logic [7:0]               errCount
);

    // state  | meaning
    // IDLE   | waiting for Receive
    // SAMPLE | Receive seen; parityErr now valid, commit byte on exit if still requested
    // ACK    | Received pulse to the receiver
    // WAIT   | hold until the receiver drops Receive

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {IDLE, SAMPLE, ACK, WAIT} state_t;

    state_t        state;
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          commit;
    logic          store;
    logic          wr_en;
    logic          rd_en;

    always_comb begin
        commit = (state == SAMPLE) && Receive;
        store  = commit && !(DROP_ERR && parityErr);
        // A full FIFO still accepts the byte when the head is popped in the same cycle
        wr_en  = store && (!full || pop);
        rd_en  = pop && !empty;
    end

    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
    assign rdData = empty ? 8'h00 : mem[rptr][7:0];
    assign rdErr  = empty ? 1'b0  : mem[rptr][8];

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state    <= IDLE;
            Received <= 1'b0;
        end else begin
            Received <= 1'b0;
            case (state)
                IDLE:   if (Receive) state <= SAMPLE;
                SAMPLE: begin
                    if (Receive) begin
                        state    <= ACK;
                        Received <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACK:    state <= WAIT;
                WAIT:   if (!Receive) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= {parityErr, Dout};
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            errCount <= 8'h00;
        end else begin
            if (wr_en) wptr <= wptr + PTR_ONE;
            if (rd_en) rptr <= rptr + PTR_ONE;
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (store && full && !pop)
                overflow <= 1'b1;
            else if (clrOverflow)
                overflow <= 1'b0;
            if (commit && parityErr && errCount != 8'hFF)
                errCount <= errCount + 8'h01;
        end
    end

endmodule

// File: tb/tb_rx_buffer.sv
// Scoreboard bench for rx_buffer: a receiver model feeds bytes, expected FIFO entries are
// queued on send and checked on pop; a second instance covers the drop-on-parity-error mode.
module tb_rx_buffer;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Receive = 1'b0;
    logic [7:0] Dout = 8'h00;
    logic       parityErr = 1'b0;
    logic       pop = 1'b0;
    logic       clrOverflow = 1'b0;

    logic       Received, rdErr, empty, full, overflow;
    logic [7:0] rdData, errCount;
    logic [3:0] count;

    logic       d_Received, d_rdErr, d_empty, d_full, d_overflow;
    logic [7:0] d_rdData, d_errCount;
    logic [3:0] d_count;

    rx_buffer #(.DEPTH(DEPTH), .DROP_ERR(1'b0)) u_keep (
        .clk(clk), .Reset(Reset), .Receive(Receive), .Dout(Dout), .parityErr(parityErr),
        .Received(Received), .pop(pop), .rdData(rdData), .rdErr(rdErr), .empty(empty),
        .full(full), .count(count), .overflow(overflow), .clrOverflow(clrOverflow),
        .errCount(errCount));

    rx_buffer #(.DEPTH(DEPTH), .DROP_ERR(1'b1)) u_drop (
        .clk(clk), .Reset(Reset), .Receive(Receive), .Dout(Dout), .parityErr(parityErr),
        .Received(d_Received), .pop(pop), .rdData(d_rdData), .rdErr(d_rdErr), .empty(d_empty),
        .full(d_full), .count(d_count), .overflow(d_overflow), .clrOverflow(clrOverflow),
        .errCount(d_errCount));

    always #5 clk = ~clk;

    int       n_cmp = 0;
    int       n_fail = 0;
    logic [8:0] sb[$];
    int       mcount = 0;
    logic     movf = 1'b0;
    int       merr = 0;

    task automatic reset_all();
        @(negedge clk);
        Reset = 1'b0;
        Receive = 1'b0;
        pop = 1'b0;
        clrOverflow = 1'b0;
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b1;
        sb.delete();
        mcount = 0;
        movf = 1'b0;
        merr = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic e, input bit pop_commit);
        int k;
        bit seen;
        logic [8:0] exp;
        @(negedge clk);
        Receive = 1'b1;
        Dout = d;
        parityErr = e;
        @(negedge clk);
        n_cmp++;
        if (Received !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_early: Received=%b required 0", Received);
        end
        if (pop_commit) begin
            exp = (sb.size() > 0) ? sb[0] : 9'h000;
            n_cmp++;
            if ({rdErr, rdData} !== exp) begin
                n_fail++;
                $display("FAIL commit_pop_head: got %h required %h", {rdErr, rdData}, exp);
            end
            pop = 1'b1;
        end
        seen = 0;
        k = 1;
        while (!seen && k < 8) begin
            @(negedge clk);
            pop = 1'b0;
            k++;
            if (Received === 1'b1) seen = 1;
        end
        if (pop_commit && sb.size() > 0) begin
            void'(sb.pop_front());
            mcount--;
        end
        if (mcount < DEPTH) begin
            sb.push_back({e, d});
            mcount++;
        end else begin
            movf = 1'b1;
        end
        if (e && merr < 255) merr++;
        n_cmp++;
        if (k !== 2) begin
            n_fail++;
            $display("FAIL ack_latency: cycles=%0d required 2", k);
        end
        Receive = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (Received !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_width: Received=%b required 0", Received);
        end
        @(negedge clk);
    endtask

    task automatic pop_check();
        logic [8:0] exp;
        @(negedge clk);
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL pop_underflow: bench queue empty, dut count=%0d", count);
        end else begin
            exp = sb.pop_front();
            mcount--;
            if ({rdErr, rdData} !== exp) begin
                n_fail++;
                $display("FAIL pop_data: got %h required %h", {rdErr, rdData}, exp);
            end
        end
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        n_cmp++;
        if (count !== 4'(mcount)) begin
            n_fail++;
            $display("FAIL pop_count: count=%0d required %0d", count, mcount);
        end
    endtask

    task automatic test_reset();
        reset_all();
        n_cmp++;
        if ({Received, rdData, rdErr, empty, full, count, overflow, errCount} !==
            {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_state: Rcv=%b data=%h err=%b empty=%b full=%b count=%0d ovf=%b errc=%0d required 0 00 0 1 0 0 0 0",
                     Received, rdData, rdErr, empty, full, count, overflow, errCount);
        end
    endtask

    task automatic test_single();
        send_byte(8'hA5, 1'b0, 0);
        n_cmp++;
        if ({rdData, rdErr, count} !== {8'hA5, 1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL single_head: data=%h err=%b count=%0d required a5 0 1", rdData, rdErr, count);
        end
        pop_check();
        n_cmp++;
        if ({empty, rdData} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL single_empty: empty=%b data=%h required 1 00", empty, rdData);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 1'b0, 0);
        n_cmp++;
        if ({full, overflow, count} !== {1'b1, 1'b0, 4'd8}) begin
            n_fail++;
            $display("FAIL fill: full=%b ovf=%b count=%0d required 1 0 8", full, overflow, count);
        end
        send_byte(8'h08, 1'b0, 0);
        n_cmp++;
        if ({full, overflow, count} !== {1'b1, movf, 4'(mcount)}) begin
            n_fail++;
            $display("FAIL overflow: full=%b ovf=%b count=%0d required 1 %b %0d", full, overflow, count, movf, mcount);
        end
        for (int i = 0; i < DEPTH; i++) pop_check();
        @(negedge clk);
        clrOverflow = 1'b1;
        @(negedge clk);
        clrOverflow = 1'b0;
        movf = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_overflow: ovf=%b required 0", overflow);
        end
    endtask

    task automatic test_parity();
        send_byte(8'h3C, 1'b1, 0);
        n_cmp++;
        if ({rdData, rdErr, errCount} !== {8'h3C, 1'b1, 8'd1}) begin
            n_fail++;
            $display("FAIL parity_keep: data=%h err=%b errc=%0d required 3c 1 1", rdData, rdErr, errCount);
        end
        n_cmp++;
        if ({d_count, d_empty, d_errCount} !== {4'd0, 1'b1, 8'd1}) begin
            n_fail++;
            $display("FAIL parity_drop: count=%0d empty=%b errc=%0d required 0 1 1", d_count, d_empty, d_errCount);
        end
        pop_check();
    endtask

    task automatic test_err_saturate();
        for (int i = 0; i < 300; i++) send_byte(8'(i), 1'b1, 0);
        n_cmp++;
        if ({errCount, d_errCount} !== {8'(merr), 8'd255}) begin
            n_fail++;
            $display("FAIL err_saturate: errc=%0d drop_errc=%0d required %0d 255", errCount, d_errCount, merr);
        end
        n_cmp++;
        if ({overflow, d_count} !== {movf, 4'd0}) begin
            n_fail++;
            $display("FAIL err_flood: ovf=%b drop_count=%0d required %b 0", overflow, d_count, movf);
        end
        reset_all();
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < DEPTH; i++) send_byte(8'h10 + 8'(i), 1'b0, 0);
        send_byte(8'h55, 1'b0, 1);
        n_cmp++;
        if ({count, overflow, full} !== {4'd8, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL full_pop: count=%0d ovf=%b full=%b required 8 0 1", count, overflow, full);
        end
        for (int i = 0; i < DEPTH; i++) pop_check();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i), 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            send_byte(8'h80 + 8'(i), (i % 3) == 0, 0);
            pop_check();
        end
        for (int i = 0; i < 3; i++) pop_check();
        n_cmp++;
        if ({empty, errCount} !== {1'b1, 8'(merr)}) begin
            n_fail++;
            $display("FAIL wrap_end: empty=%b errc=%0d required 1 %0d", empty, errCount, merr);
        end
    endtask

    task automatic test_abort();
        @(negedge clk);
        Receive = 1'b1;
        Dout = 8'hEE;
        parityErr = 1'b0;
        @(negedge clk);
        Receive = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (Received !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_ack: Received=%b required 0", Received);
            end
        end
        n_cmp++;
        if (count !== 4'(mcount)) begin
            n_fail++;
            $display("FAIL abort_count: count=%0d required %0d", count, mcount);
        end
        send_byte(8'h66, 1'b0, 0);
        pop_check();
    endtask

    task automatic test_reset_in_ack();
        for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i), 1'b0, 0);
        @(negedge clk);
        Receive = 1'b1;
        Dout = 8'h99;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (Received !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_state: Received=%b required 1", Received);
        end
        Reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({Received, count, empty} !== {1'b0, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_in_ack: Received=%b count=%0d empty=%b required 0 0 1", Received, count, empty);
        end
        Receive = 1'b0;
        Reset = 1'b1;
        sb.delete();
        mcount = 0;
        movf = 1'b0;
        merr = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_parity();
        test_err_saturate();
        test_full_pop();
        test_wrap();
        test_abort();
        test_reset_in_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
